// File: rtl/key_conditioner.sv
// Pushbutton conditioner: turns the raw, bouncing, active-low start and mode
// buttons into a one-clk start pulse and a debounced toggling mode level.

// One debounce channel: 2-FF synchronizer, counter and 4-state press/release FSM.
module key_conditioner_channel #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic key_reset,
    input  logic btn_n_i,
    output logic fire_c,
    output logic held_c
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } state_e;

    logic [1:0]       sync_q;
    logic             pressed;
    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Two-stage synchronizer; resets to the released level.
    always_ff @(posedge clk or posedge key_reset) begin
        if (key_reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], btn_n_i};
        end
    end

    assign pressed = ~sync_q[1];

    // State and debounce counter registers.
    always_ff @(posedge clk or posedge key_reset) begin
        if (key_reset) begin
            state_q <= ST_RELEASE_WAIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: accept a level only after DEBOUNCE_CYCLES stable samples.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fire_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pressed) begin
                    state_d = ST_PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!pressed) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_PRESSED;
                    fire_c  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_PRESSED: begin
                if (!pressed) begin
                    state_d = ST_RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_RELEASE_WAIT: begin
                if (pressed) begin
                    state_d = ST_PRESSED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_RELEASE_WAIT;
                cnt_d   = '0;
            end
        endcase
    end

    // Held while the accepted level is "pressed" (release still being debounced counts).
    assign held_c = (state_q == ST_PRESSED) || (state_q == ST_RELEASE_WAIT);

endmodule

module key_conditioner #(
    parameter int unsigned IN_CLK_HZ       = 50_000_000,
    parameter int unsigned DEBOUNCE_CYCLES = IN_CLK_HZ / 50,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic key_reset,
    input  logic btn_start_n,
    input  logic btn_mod_n,
    output logic key_start,
    output logic mod,
    output logic start_held
);

    logic start_fire_c;
    logic mod_fire_c;
    logic start_held_c;
    logic mod_held_c;
    logic key_start_q;
    logic mod_q;

    key_conditioner_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_start (
        .clk       (clk),
        .key_reset (key_reset),
        .btn_n_i   (btn_start_n),
        .fire_c    (start_fire_c),
        .held_c    (start_held_c)
    );

    key_conditioner_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_mod (
        .clk       (clk),
        .key_reset (key_reset),
        .btn_n_i   (btn_mod_n),
        .fire_c    (mod_fire_c),
        .held_c    (mod_held_c)
    );

    // Start pulse lasts the single cycle after acceptance; mode flips on the same edge.
    always_ff @(posedge clk or posedge key_reset) begin
        if (key_reset) begin
            key_start_q <= 1'b0;
            mod_q       <= 1'b0;
        end else begin
            key_start_q <= start_fire_c;
            mod_q       <= mod_q ^ mod_fire_c;
        end
    end

    assign key_start  = key_start_q;
    assign mod        = mod_q;
    assign start_held = start_held_c;

    logic unused_mod_held;
    assign unused_mod_held = mod_held_c;

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: run-length debounce model plus directed and random stimulus.
module tb_key_conditioner;

    localparam int unsigned N = 8;

    logic clk = 1'b0;
    logic key_reset;
    logic btn_start_n;
    logic btn_mod_n;
    logic key_start;
    logic mod;
    logic start_held;

    always #5 clk = ~clk;

    key_conditioner #(
        .DEBOUNCE_CYCLES (N)
    ) dut (
        .clk         (clk),
        .key_reset   (key_reset),
        .btn_start_n (btn_start_n),
        .btn_mod_n   (btn_mod_n),
        .key_start   (key_start),
        .mod         (mod),
        .start_held  (start_held)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Model: a button's accepted level flips once N+1 consecutive synchronized
    // samples disagree with it; reset counts as one released sample already seen.
    typedef struct packed {
        logic       lvl;
        logic       ev;
        logic [7:0] dis;
    } ch_t;

    function automatic ch_t step(input ch_t c, input logic p);
        ch_t n;
        n    = c;
        n.ev = 1'b0;
        if (p == c.lvl) begin
            n.dis = 8'd0;
        end else if (c.dis == 8'(N)) begin
            n.lvl = p;
            n.dis = 8'd0;
            n.ev  = p;
        end else begin
            n.dis = c.dis + 8'd1;
        end
        return n;
    endfunction

    logic [1:0] s_sync;
    logic [1:0] m_sync;
    ch_t        s_ch;
    ch_t        m_ch;
    logic       mod_par;
    int         edge_cnt = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    always @(posedge clk or posedge key_reset) begin
        if (key_reset) begin
            s_sync  <= 2'b11;
            m_sync  <= 2'b11;
            s_ch    <= '{lvl: 1'b1, ev: 1'b0, dis: 8'd1};
            m_ch    <= '{lvl: 1'b1, ev: 1'b0, dis: 8'd1};
            mod_par <= 1'b0;
        end else begin
            s_sync  <= {s_sync[0], btn_start_n};
            m_sync  <= {m_sync[0], btn_mod_n};
            s_ch    <= step(s_ch, ~s_sync[1]);
            m_ch    <= step(m_ch, ~m_sync[1]);
            mod_par <= mod_par ^ m_ch.ev;
        end
    end

    int   ks_q[$];
    int   mt_q[$];
    int   hf_q[$];
    logic prev_mod  = 1'b0;
    logic prev_held = 1'b1;

    // Compare every cycle away from the active edge and log events for directed checks.
    initial begin
        forever begin
            @(negedge clk);
            if (key_reset) begin
                chk("rst_key_start", int'(key_start), 0);
                chk("rst_mod", int'(mod), 0);
                chk("rst_start_held", int'(start_held), 1);
            end else begin
                chk("key_start", int'(key_start), int'(s_ch.ev));
                chk("mod", int'(mod), int'(mod_par ^ m_ch.ev));
                chk("start_held", int'(start_held), int'(s_ch.lvl));
                if (key_start) ks_q.push_back(edge_cnt);
                if (mod != prev_mod) mt_q.push_back(edge_cnt);
                if (prev_held && !start_held) hf_q.push_back(edge_cnt);
            end
            prev_mod  = mod;
            prev_held = start_held;
        end
    end

    task automatic hold(input logic s, input logic m, input int n);
        btn_start_n = s;
        btn_mod_n   = m;
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_logs();
        ks_q.delete();
        mt_q.delete();
        hf_q.delete();
    endtask

    function automatic int first(input int q[$]);
        return (q.size() > 0) ? q[0] : -1;
    endfunction

    int k;
    int kk[3];
    int cs;
    int cm;

    initial begin
        key_reset   = 1'b1;
        btn_start_n = 1'b1;
        btn_mod_n   = 1'b1;
        repeat (3) @(negedge clk);
        key_reset = 1'b0;
        hold(1, 1, 20);

        // Clean press: pulse exactly N+2 edges after the first low sample.
        clear_logs();
        k = edge_cnt + 1;
        hold(0, 1, 50);
        chk("t1_pulse_count", ks_q.size(), 1);
        chk("t1_pulse_edge", first(ks_q), k + 10);
        hold(1, 1, 20);

        // Press bounce.
        clear_logs();
        hold(0, 1, 3);
        hold(1, 1, 2);
        hold(0, 1, 5);
        hold(1, 1, 1);
        k = edge_cnt + 1;
        hold(0, 1, 30);
        chk("t2_pulse_count", ks_q.size(), 1);
        chk("t2_pulse_edge", first(ks_q), k + 10);
        hold(1, 1, 20);

        // Release bounce.
        clear_logs();
        hold(0, 1, 20);
        hold(1, 1, 4);
        hold(0, 1, 2);
        hf_q.delete();
        k = edge_cnt + 1;
        hold(1, 1, 20);
        chk("t3_pulse_count", ks_q.size(), 1);
        chk("t3_held_fall_count", hf_q.size(), 1);
        chk("t3_held_fall_edge", first(hf_q), k + 10);

        // Three mode presses.
        clear_logs();
        for (int i = 0; i < 3; i++) begin
            kk[i] = edge_cnt + 1;
            hold(1, 0, 20);
            hold(1, 1, 30);
        end
        chk("t4_toggle_count", mt_q.size(), 3);
        for (int i = 0; i < 3; i++)
            chk("t4_toggle_edge", (mt_q.size() > i) ? mt_q[i] : -1, kk[i] + 10);
        chk("t4_no_start", ks_q.size(), 0);
        chk("t4_mod_final", int'(mod), 1);

        // Simultaneous press.
        clear_logs();
        k = edge_cnt + 1;
        hold(0, 0, 20);
        chk("t5_pulse_count", ks_q.size(), 1);
        chk("t5_toggle_count", mt_q.size(), 1);
        chk("t5_pulse_edge", first(ks_q), k + 10);
        chk("t5_toggle_edge", first(mt_q), k + 10);
        chk("t5_mod", int'(mod), 0);
        hold(1, 1, 20);

        // Reset while start is held.
        hold(0, 0, 20);
        clear_logs();
        btn_mod_n = 1'b1;
        key_reset = 1'b1;
        repeat (3) @(negedge clk);
        key_reset = 1'b0;
        hold(0, 1, 20);
        chk("t6_no_pulse", ks_q.size(), 0);
        chk("t6_mod_cleared", int'(mod), 0);
        chk("t6_held", int'(start_held), 1);
        hold(1, 1, 10);
        k = edge_cnt + 1;
        hold(0, 1, 20);
        chk("t6_pulse_count", ks_q.size(), 1);
        chk("t6_pulse_edge", first(ks_q), k + 10);
        hold(1, 1, 20);

        // Random bouncing on both buttons with occasional resets.
        cs = 1;
        cm = 1;
        for (int c = 0; c < 3000; c++) begin
            if (cs == 0) begin
                btn_start_n = ~btn_start_n;
                cs = $urandom_range(1, 20);
            end
            if (cm == 0) begin
                btn_mod_n = ~btn_mod_n;
                cm = $urandom_range(1, 20);
            end
            cs--;
            cm--;
            if ($urandom_range(0, 499) == 0) begin
                key_reset = 1'b1;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                key_reset = 1'b0;
            end
            @(negedge clk);
        end
        hold(1, 1, 20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
